// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: byte-stream command sequencer between uart_rx and ram_block.
// Commands: 'W' addr data (RAM write), 'R' addr (RAM read into leds), 'L' data (load leds).
// Optional build macro UART_CMD_CLEAR_EN adds 'C', which zero-fills the whole RAM.
// Byte handshake: byte_valid is a level from uart_rx; a byte is taken on its rising
// edge only (one accept per high phase), with byte_data/rx_error sampled in that cycle.
module uart_cmd_ctrl #(
   parameter int          ADDR_W         = 8,
   parameter int          TIMEOUT_CYCLES = 1200000,
   parameter logic [7:0]  LED_RESET      = 8'h01
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   input  logic              rx_error,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [7:0]        ram_wdata,
   input  logic [7:0]        ram_rdata,
   output logic [7:0]        leds,
   output logic              busy,
   output logic [7:0]        err_count
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [7:0] CH_W = 8'h57;
   localparam logic [7:0] CH_R = 8'h52;
   localparam logic [7:0] CH_L = 8'h4C;
`ifdef UART_CMD_CLEAR_EN
   localparam logic [7:0] CH_C = 8'h43;
`endif

   localparam logic [1:0] CMD_W = 2'd0;
   localparam logic [1:0] CMD_R = 2'd1;
   localparam logic [1:0] CMD_L = 2'd2;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_GET_ADDR  = 3'd1,
      S_GET_DATA  = 3'd2,
      S_READ_WAIT = 3'd3,
      S_READ_LOAD = 3'd4
`ifdef UART_CMD_CLEAR_EN
      ,S_CLEAR    = 3'd5
`endif
   } state_t;

   state_t          state, state_next;
   logic            valid_q;
   logic            accept;
   logic            in_read;
   logic            parse;
   logic            skid_full;
   logic [7:0]      skid_data;
   logic            skid_err;
   logic            use_skid;
   logic            eff_valid;
   logic [7:0]      eff_data;
   logic            eff_err;
   logic            eff_ok;
   logic            eff_bad;
   logic [TW-1:0]   to_cnt;
   logic            timed_out;
   logic [1:0]      cmd_q;

   // decoded actions for the datapath registers
   logic            cmd_load;
   logic [1:0]      cmd_next;
   logic            addr_load;
   logic            wr_fire;
   logic            led_load_byte;
   logic            led_load_rd;
   logic            err_inc;
`ifdef UART_CMD_CLEAR_EN
   logic            clr_start;
   logic            clr_active;
   logic [ADDR_W-1:0] clr_addr;
`endif

   assign accept   = byte_valid & ~valid_q;
   assign in_read  = (state == S_READ_WAIT) || (state == S_READ_LOAD);
   assign parse    = (state == S_GET_ADDR) || (state == S_GET_DATA);
   // A parked byte is replayed in IDLE ahead of anything arriving in the same cycle.
   assign use_skid = (state == S_IDLE) && skid_full;
`ifdef UART_CMD_CLEAR_EN
   assign eff_valid = use_skid | (accept & ~in_read & (state != S_CLEAR));
`else
   assign eff_valid = use_skid | (accept & ~in_read);
`endif
   assign eff_data  = use_skid ? skid_data : byte_data;
   assign eff_err   = use_skid ? skid_err  : rx_error;
   assign eff_ok    = eff_valid & ~eff_err;
   assign eff_bad   = eff_valid & eff_err;
   // A byte arriving on the expiry cycle wins over the timeout.
   assign timed_out = parse && (to_cnt == TW'(TIMEOUT_CYCLES - 1)) && !eff_valid;

   // Rising-edge history for byte_valid.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) valid_q <= 1'b0;
      else          valid_q <= byte_valid;
   end

   // Skid register: parks a byte that lands while a read is in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         skid_full <= 1'b0;
         skid_data <= 8'h00;
         skid_err  <= 1'b0;
      end else if (accept && (in_read || use_skid)) begin
         skid_full <= 1'b1;
         skid_data <= byte_data;
         skid_err  <= rx_error;
      end else if (use_skid) begin
         skid_full <= 1'b0;
      end
   end

   // Inter-byte timeout counter, only running while a command is being parsed.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                  to_cnt <= '0;
      else if (accept || use_skid)   to_cnt <= '0;
      else if (parse && !timed_out)  to_cnt <= to_cnt + TW'(1);
      else                           to_cnt <= '0;
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_next;
   end

   // FSM next-state logic.
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: begin
            if (eff_ok) begin
               case (eff_data)
                  CH_W, CH_R: state_next = S_GET_ADDR;
                  CH_L:       state_next = S_GET_DATA;
`ifdef UART_CMD_CLEAR_EN
                  CH_C:       state_next = S_CLEAR;
`endif
                  default:    state_next = S_IDLE;
               endcase
            end
         end
         S_GET_ADDR: begin
            if (eff_bad)        state_next = S_IDLE;
            else if (eff_ok)    state_next = (cmd_q == CMD_R) ? S_READ_WAIT : S_GET_DATA;
            else if (timed_out) state_next = S_IDLE;
         end
         S_GET_DATA: begin
            if (eff_valid || timed_out) state_next = S_IDLE;
         end
         S_READ_WAIT: state_next = S_READ_LOAD;
         S_READ_LOAD: state_next = S_IDLE;
`ifdef UART_CMD_CLEAR_EN
         S_CLEAR: begin
            if (clr_addr == {ADDR_W{1'b1}}) state_next = S_IDLE;
         end
`endif
         default: state_next = S_IDLE;
      endcase
   end

   // FSM output decode: per-state actions for the datapath and the busy flag.
   always_comb begin
      cmd_load      = 1'b0;
      cmd_next      = cmd_q;
      addr_load     = 1'b0;
      wr_fire       = 1'b0;
      led_load_byte = 1'b0;
      led_load_rd   = 1'b0;
      err_inc       = 1'b0;
`ifdef UART_CMD_CLEAR_EN
      clr_start     = 1'b0;
      clr_active    = 1'b0;
`endif
      busy          = (state != S_IDLE);
      case (state)
         S_IDLE: begin
            if (eff_bad) err_inc = 1'b1;
            else if (eff_ok) begin
               case (eff_data)
                  CH_W: begin cmd_load = 1'b1; cmd_next = CMD_W; end
                  CH_R: begin cmd_load = 1'b1; cmd_next = CMD_R; end
                  CH_L: begin cmd_load = 1'b1; cmd_next = CMD_L; end
`ifdef UART_CMD_CLEAR_EN
                  CH_C: clr_start = 1'b1;
`endif
                  default: err_inc = 1'b1;
               endcase
            end
         end
         S_GET_ADDR: begin
            if (eff_bad)        err_inc   = 1'b1;
            else if (eff_ok)    addr_load = 1'b1;
            else if (timed_out) err_inc   = 1'b1;
         end
         S_GET_DATA: begin
            if (eff_bad) err_inc = 1'b1;
            else if (eff_ok) begin
               if (cmd_q == CMD_W) wr_fire       = 1'b1;
               else                led_load_byte = 1'b1;
            end else if (timed_out) err_inc = 1'b1;
         end
         S_READ_LOAD: led_load_rd = 1'b1;
`ifdef UART_CMD_CLEAR_EN
         S_CLEAR: begin
            clr_active = 1'b1;
            if (accept) err_inc = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   // Datapath registers: RAM port, LED register, command latch, error counter.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ram_we    <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= 8'h00;
         leds      <= LED_RESET;
         err_count <= 8'h00;
         cmd_q     <= CMD_W;
      end else begin
         ram_we <= wr_fire;
         if (cmd_load)      cmd_q     <= cmd_next;
         if (addr_load)     ram_addr  <= eff_data[ADDR_W-1:0];
         if (wr_fire)       ram_wdata <= eff_data;
         if (led_load_byte) leds      <= eff_data;
         else if (led_load_rd) leds   <= ram_rdata;
         if (err_inc && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
`ifdef UART_CMD_CLEAR_EN
         if (clr_active) begin
            ram_we    <= 1'b1;
            ram_addr  <= clr_addr;
            ram_wdata <= 8'h00;
         end
`endif
      end
   end

`ifdef UART_CMD_CLEAR_EN
   // Clear sweep address: restarts on 'C', steps once per CLEAR cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)        clr_addr <= '0;
      else if (clr_start)  clr_addr <= '0;
      else if (clr_active) clr_addr <= clr_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
   end
`endif

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl with a registered-read RAM model and a write log.
module tb_uart_cmd_ctrl;

   localparam int ADDR_W = 4;
   localparam int TO     = 40;
   localparam int EW     = ADDR_W + 8;

   logic              clk;
   logic              reset_n;
   logic              byte_valid;
   logic [7:0]        byte_data;
   logic              rx_error;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [7:0]        ram_wdata;
   logic [7:0]        ram_rdata;
   logic [7:0]        leds;
   logic              busy;
   logic [7:0]        err_count;

   logic [7:0]        mem [16];
   logic [EW-1:0]     exp_q [$];
   logic [EW-1:0]     got_q [$];
   logic              we_prev;
   logic              we_double;
   int                n_checks;
   int                n_pass;

   uart_cmd_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TO), .LED_RESET(8'h01)) dut (
      .clk(clk), .reset_n(reset_n), .byte_valid(byte_valid), .byte_data(byte_data),
      .rx_error(rx_error), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .leds(leds), .busy(busy), .err_count(err_count)
   );

   // clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // RAM model: synchronous write, registered read
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
   end

   // write monitor
   always @(posedge clk) begin
      if (reset_n) begin
         if (ram_we) begin
            got_q.push_back({ram_addr, ram_wdata});
            if (we_prev) we_double = 1'b1;
         end
         we_prev = ram_we;
      end else begin
         we_prev = 1'b0;
      end
   end

   // driver: raise byte_valid for one cycle; returns on the negedge after the accept edge
   task automatic send_byte(input logic [7:0] d, input logic e);
      @(negedge clk);
      byte_data  = d;
      rx_error   = e;
      byte_valid = 1'b1;
      @(negedge clk);
      byte_valid = 1'b0;
      rx_error   = 1'b0;
   endtask

   task automatic check8(input string name, input logic [7:0] got, input logic [7:0] exp);
   endtask

   task automatic test_reset;
      reset_n = 1'b0; byte_valid = 1'b0; byte_data = 8'h00; rx_error = 1'b0;
      we_double = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++; if (leds !== 8'h01) $display("FAIL reset_leds: got %h exp 01", leds); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b exp 0", busy); else n_pass++;
      n_checks++; if (err_count !== 8'h00) $display("FAIL reset_err: got %h exp 00", err_count); else n_pass++;
      n_checks++; if (ram_we !== 1'b0) $display("FAIL reset_we: got %b exp 0", ram_we); else n_pass++;
      n_checks++; if (ram_addr !== 4'h0) $display("FAIL reset_addr: got %h exp 0", ram_addr); else n_pass++;
      n_checks++; if (ram_wdata !== 8'h00) $display("FAIL reset_wdata: got %h exp 00", ram_wdata); else n_pass++;
      reset_n = 1'b1;
   endtask

   task automatic test_write_read;
      got_q.delete(); exp_q.delete();
      send_byte(8'h57, 1'b0);
      send_byte(8'h05, 1'b0);
      send_byte(8'hA5, 1'b0);
      exp_q.push_back({4'h5, 8'hA5});
      n_checks++; if (ram_we !== 1'b1) $display("FAIL wr_we: got %b exp 1", ram_we); else n_pass++;
      n_checks++; if (ram_addr !== 4'h5) $display("FAIL wr_addr: got %h exp 5", ram_addr); else n_pass++;
      n_checks++; if (ram_wdata !== 8'hA5) $display("FAIL wr_wdata: got %h exp a5", ram_wdata); else n_pass++;
      @(negedge clk);
      n_checks++; if (ram_we !== 1'b0) $display("FAIL wr_we_pulse: got %b exp 0", ram_we); else n_pass++;
      send_byte(8'h52, 1'b0);
      send_byte(8'h05, 1'b0);
      n_checks++; if (busy !== 1'b1) $display("FAIL rd_busy: got %b exp 1", busy); else n_pass++;
      @(negedge clk);
      n_checks++; if (leds !== 8'h01) $display("FAIL rd_leds_early: got %h exp 01", leds); else n_pass++;
      @(negedge clk);
      n_checks++; if (leds !== 8'hA5) $display("FAIL rd_leds: got %h exp a5", leds); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL rd_busy_end: got %b exp 0", busy); else n_pass++;
      n_checks++; if (err_count !== 8'h00) $display("FAIL wr_rd_err: got %h exp 00", err_count); else n_pass++;
      n_checks++;
      if (got_q.size() != 1 || got_q[0] !== exp_q[0])
         $display("FAIL wr_log: got %0d writes (first %h) exp 1 write %h", got_q.size(), (got_q.size() > 0) ? got_q[0] : '0, exp_q[0]);
      else n_pass++;
   endtask

   task automatic test_led_load;
      got_q.delete();
      send_byte(8'h4C, 1'b0);
      n_checks++; if (leds !== 8'hA5) $display("FAIL led_before: got %h exp a5", leds); else n_pass++;
      send_byte(8'h3C, 1'b0);
      n_checks++; if (leds !== 8'h3C) $display("FAIL led_load: got %h exp 3c", leds); else n_pass++;
      repeat (2) @(negedge clk);
      n_checks++; if (got_q.size() != 0) $display("FAIL led_no_write: got %0d writes exp 0", got_q.size()); else n_pass++;
   endtask

   task automatic test_timeout;
      got_q.delete();
      send_byte(8'h99, 1'b0);
      n_checks++; if (err_count !== 8'h01) $display("FAIL unk_err: got %h exp 01", err_count); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL unk_busy: got %b exp 0", busy); else n_pass++;
      send_byte(8'h57, 1'b0);
      send_byte(8'h01, 1'b0);
      repeat (TO - 1) @(negedge clk);
      n_checks++; if (busy !== 1'b1) $display("FAIL to_early: got busy %b exp 1", busy); else n_pass++;
      @(negedge clk);
      n_checks++; if (busy !== 1'b0) $display("FAIL to_busy: got %b exp 0", busy); else n_pass++;
      n_checks++; if (err_count !== 8'h02) $display("FAIL to_err: got %h exp 02", err_count); else n_pass++;
      n_checks++; if (got_q.size() != 0) $display("FAIL to_no_write: got %0d writes exp 0", got_q.size()); else n_pass++;
      n_checks++; if (leds !== 8'h3C) $display("FAIL to_leds: got %h exp 3c", leds); else n_pass++;
   endtask

   task automatic test_rx_error;
      got_q.delete();
      send_byte(8'h57, 1'b0);
      send_byte(8'h07, 1'b1);
      n_checks++; if (busy !== 1'b0) $display("FAIL rxerr_busy: got %b exp 0", busy); else n_pass++;
      n_checks++; if (err_count !== 8'h03) $display("FAIL rxerr_err: got %h exp 03", err_count); else n_pass++;
      send_byte(8'h4C, 1'b0);
      send_byte(8'h0F, 1'b0);
      n_checks++; if (leds !== 8'h0F) $display("FAIL rxerr_leds: got %h exp 0f", leds); else n_pass++;
      n_checks++; if (got_q.size() != 0) $display("FAIL rxerr_no_write: got %0d writes exp 0", got_q.size()); else n_pass++;
   endtask

   task automatic test_skid;
      send_byte(8'h52, 1'b0);
      send_byte(8'h05, 1'b0);
      send_byte(8'h4C, 1'b0);   // lands during READ_LOAD
      n_checks++; if (leds !== 8'hA5) $display("FAIL skid_read: got %h exp a5", leds); else n_pass++;
      send_byte(8'h5A, 1'b0);
      n_checks++; if (leds !== 8'h5A) $display("FAIL skid_leds: got %h exp 5a", leds); else n_pass++;
      n_checks++; if (err_count !== 8'h03) $display("FAIL skid_err: got %h exp 03", err_count); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL skid_busy: got %b exp 0", busy); else n_pass++;
   endtask

   task automatic test_back_to_back;
      got_q.delete(); exp_q.delete(); we_double = 1'b0;
      send_byte(8'h57, 1'b0); send_byte(8'h08, 1'b0); send_byte(8'h11, 1'b0);
      send_byte(8'h57, 1'b0); send_byte(8'h09, 1'b0); send_byte(8'h22, 1'b0);
      exp_q.push_back({4'h8, 8'h11});
      exp_q.push_back({4'h9, 8'h22});
      send_byte(8'h52, 1'b0); send_byte(8'h09, 1'b0);
      repeat (2) @(negedge clk);
      n_checks++; if (leds !== 8'h22) $display("FAIL b2b_read: got %h exp 22", leds); else n_pass++;
      n_checks++;
      if (got_q.size() != 2) $display("FAIL b2b_count: got %0d writes exp 2", got_q.size());
      else if (got_q[0] !== exp_q[0] || got_q[1] !== exp_q[1])
         $display("FAIL b2b_log: got %h %h exp %h %h", got_q[0], got_q[1], exp_q[0], exp_q[1]);
      else n_pass++;
      n_checks++; if (we_double !== 1'b0) $display("FAIL b2b_we_double: got %b exp 0", we_double); else n_pass++;
   endtask

   task automatic test_reset_mid;
      send_byte(8'h57, 1'b0);
      send_byte(8'h02, 1'b0);
      n_checks++; if (busy !== 1'b1) $display("FAIL rstmid_busy_pre: got %b exp 1", busy); else n_pass++;
      #1 reset_n = 1'b0;
      #1;
      n_checks++; if (leds !== 8'h01) $display("FAIL rstmid_leds: got %h exp 01", leds); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b exp 0", busy); else n_pass++;
      n_checks++; if (err_count !== 8'h00) $display("FAIL rstmid_err: got %h exp 00", err_count); else n_pass++;
      n_checks++; if (ram_addr !== 4'h0) $display("FAIL rstmid_addr: got %h exp 0", ram_addr); else n_pass++;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      send_byte(8'h4C, 1'b0);
      send_byte(8'h80, 1'b0);
      n_checks++; if (leds !== 8'h80) $display("FAIL rstmid_load: got %h exp 80", leds); else n_pass++;
   endtask

`ifdef UART_CMD_CLEAR_EN
   task automatic test_clear;
      got_q.delete(); exp_q.delete();
      for (int i = 0; i < 16; i++) exp_q.push_back({i[3:0], 8'h00});
      send_byte(8'h43, 1'b0);
      n_checks++; if (busy !== 1'b1) $display("FAIL clr_busy: got %b exp 1", busy); else n_pass++;
      send_byte(8'h57, 1'b0);   // dropped mid-clear
      n_checks++; if (err_count !== 8'h01) $display("FAIL clr_err: got %h exp 01", err_count); else n_pass++;
      repeat (20) @(negedge clk);
      n_checks++; if (busy !== 1'b0) $display("FAIL clr_done: got %b exp 0", busy); else n_pass++;
      n_checks++; if (leds !== 8'h80) $display("FAIL clr_leds: got %h exp 80", leds); else n_pass++;
      n_checks++;
      if (got_q.size() != 16) $display("FAIL clr_count: got %0d writes exp 16", got_q.size());
      else if (got_q != exp_q) $display("FAIL clr_log: got first %h last %h exp 000 f00", got_q[0], got_q[15]);
      else n_pass++;
   endtask
`else
   task automatic test_unknown_c;
      send_byte(8'h43, 1'b0);
      n_checks++; if (err_count !== 8'h01) $display("FAIL c_unknown_err: got %h exp 01", err_count); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL c_unknown_busy: got %b exp 0", busy); else n_pass++;
   endtask
`endif

   task automatic test_saturate;
      // err_count is 1 here; 253 more bad bytes reach FE
      for (int i = 0; i < 253; i++) send_byte(8'h00, 1'b0);
      n_checks++; if (err_count !== 8'hFE) $display("FAIL sat_fe: got %h exp fe", err_count); else n_pass++;
      send_byte(8'h00, 1'b0);
      n_checks++; if (err_count !== 8'hFF) $display("FAIL sat_ff: got %h exp ff", err_count); else n_pass++;
      send_byte(8'h00, 1'b0);
      send_byte(8'h4C, 1'b1);
      n_checks++; if (err_count !== 8'hFF) $display("FAIL sat_hold: got %h exp ff", err_count); else n_pass++;
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      test_reset();
      test_write_read();
      test_led_load();
      test_timeout();
      test_rx_error();
      test_skid();
      test_back_to_back();
      test_reset_mid();
`ifdef UART_CMD_CLEAR_EN
      test_clear();
`else
      test_unknown_c();
`endif
      test_saturate();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
